// File: rtl/board_mine_gen.sv
// board_mine_gen: builds a fresh minefield on start. Places M mines on an
// N x N grid from a free-running LFSR, computes each field's neighbour count
// and writes one byte per field to board memory over a wishbone-style master.
// Optional feature macro: SAFE_ZONE_EN adds safe_row/safe_col and keeps the
// 3x3 block around that field free of mines.
module board_mine_gen #(
   parameter int unsigned MAX_DIM   = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] row_col_num,
   input  logic [7:0] mine_num,
`ifdef SAFE_ZONE_EN
   input  logic [3:0] safe_row,
   input  logic [3:0] safe_col,
`endif
   input  logic       wb_ack_i,
   output logic       busy,
   output logic       done,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PLACE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t       state_q;
   logic [15:0]  lfsr_q, lfsr_d;
   logic [4:0]   n_q;
   logic [7:0]   m_q;
   logic [7:0]   placed_q;
   logic [255:0] bitmap_q;
   logic [3:0]   row_q, col_q;
   logic         busy_q, done_q, cyc_q, stb_q;
   logic [7:0]   adr_q, dat_q;
`ifdef SAFE_ZONE_EN
   logic [3:0]   safe_r_q, safe_c_q;
`endif

   logic [4:0]   n_in_c;
   logic [8:0]   area_c, mcap_c;
   logic [7:0]   m_in_c;
   logic [3:0]   cand_row_c, cand_col_c;
   logic         cand_ok_c;
   logic [3:0]   nbr_cnt_c;
   logic         last_field_c;

   // Number of rows (or columns) of the 3x3 block around s that lie inside an n-wide grid;
   // s-1 wraps to 31 in 5 bits and so falls out of range on its own.
   function automatic logic [8:0] span3(input logic [3:0] s, input logic [4:0] n);
      logic [8:0] cnt;
      logic [4:0] k;
      cnt = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         k = {1'b0, s} + 5'(i) - 5'd1;
         if (k < n) cnt = cnt + 9'd1;
      end
      return cnt;
   endfunction

   // Input clamps evaluated on the start cycle
   always_comb begin
      n_in_c = row_col_num;
      if (row_col_num < 5'd2) n_in_c = 5'd2;
      else if (row_col_num > 5'(MAX_DIM)) n_in_c = 5'(MAX_DIM);
      area_c = {4'b0, n_in_c} * {4'b0, n_in_c};
      mcap_c = area_c - 9'd1;
`ifdef SAFE_ZONE_EN
      if (area_c - span3(safe_row, n_in_c) * span3(safe_col, n_in_c) < mcap_c)
         mcap_c = area_c - span3(safe_row, n_in_c) * span3(safe_col, n_in_c);
`endif
      m_in_c = ({1'b0, mine_num} > mcap_c) ? mcap_c[7:0] : mine_num;
   end

   // Placement candidate from the current LFSR value
   always_comb begin
      logic [4:0] dr, dc;
      cand_row_c = lfsr_q[3:0];
      cand_col_c = lfsr_q[7:4];
      dr = '0;
      dc = '0;
      cand_ok_c = ({1'b0, cand_row_c} < n_q) && ({1'b0, cand_col_c} < n_q) &&
                  !bitmap_q[{cand_row_c, cand_col_c}];
`ifdef SAFE_ZONE_EN
      // row - safe + 1 in [0,2] means within one step; negatives wrap above 2
      dr = {1'b0, cand_row_c} - {1'b0, safe_r_q} + 5'd1;
      dc = {1'b0, cand_col_c} - {1'b0, safe_c_q} + 5'd1;
      if (dr <= 5'd2 && dc <= 5'd2) cand_ok_c = 1'b0;
`endif
   end

   // Mines among the 8 neighbours of the field currently being written
   always_comb begin
      logic [4:0] nr, nc;
      nbr_cnt_c = '0;
      nr = '0;
      nc = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         for (int unsigned j = 0; j < 3; j++) begin
            nr = {1'b0, row_q} + 5'(i) - 5'd1;
            nc = {1'b0, col_q} + 5'(j) - 5'd1;
            if (!(i == 1 && j == 1) && nr < n_q && nc < n_q) begin
               if (bitmap_q[{nr[3:0], nc[3:0]}]) nbr_cnt_c = nbr_cnt_c + 4'd1;
            end
         end
      end
      last_field_c = ({1'b0, row_q} == n_q - 5'd1) && ({1'b0, col_q} == n_q - 5'd1);
   end

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Free-running LFSR, advances every cycle regardless of state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   // Generation FSM with registered bus and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         n_q      <= 5'd2;
         m_q      <= '0;
         placed_q <= '0;
         bitmap_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
`ifdef SAFE_ZONE_EN
         safe_r_q <= '0;
         safe_c_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_q     <= n_in_c;
                  m_q     <= m_in_c;
`ifdef SAFE_ZONE_EN
                  safe_r_q <= safe_row;
                  safe_c_q <= safe_col;
`endif
                  busy_q  <= 1'b1;
                  state_q <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               bitmap_q <= '0;
               placed_q <= '0;
               row_q    <= '0;
               col_q    <= '0;
               state_q  <= S_PLACE;
            end
            S_PLACE: begin
               if (placed_q == m_q) begin
                  state_q <= S_WRITE;
               end else if (cand_ok_c) begin
                  bitmap_q[{cand_row_c, cand_col_c}] <= 1'b1;
                  placed_q <= placed_q + 8'd1;
                  if (placed_q + 8'd1 == m_q) state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               // stb low here is either WRITE entry or the one-cycle gap after an ack
               if (!stb_q) begin
                  cyc_q <= 1'b1;
                  stb_q <= 1'b1;
                  adr_q <= {row_q, col_q};
                  dat_q <= {bitmap_q[{row_q, col_q}], 3'b000, nbr_cnt_c};
               end else if (wb_ack_i) begin
                  cyc_q <= 1'b0;
                  stb_q <= 1'b0;
                  if (last_field_c) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else if ({1'b0, col_q} == n_q - 5'd1) begin
                     col_q <= '0;
                     row_q <= row_q + 4'd1;
                  end else begin
                     col_q <= col_q + 4'd1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = stb_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_board_mine_gen.sv
// Self-checking bench for board_mine_gen: a bus slave with random ack latency
// records every write, then the board is checked against the clamp rules,
// row-major address order and neighbour counts recomputed from the written mines.
module tb_board_mine_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [4:0] row_col_num = '0;
   logic [7:0] mine_num = '0;
   logic       wb_ack_i = 1'b0;
   logic       busy, done, wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0] wb_adr_o, wb_dat_o;
`ifdef SAFE_ZONE_EN
   logic [3:0] safe_row = '0;
   logic [3:0] safe_col = '0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam int BUDGET = 20000;

   always #5 clk = ~clk;

   board_mine_gen #(.MAX_DIM(16), .LFSR_SEED(16'hACE1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .row_col_num (row_col_num),
      .mine_num    (mine_num),
`ifdef SAFE_ZONE_EN
      .safe_row    (safe_row),
      .safe_col    (safe_col),
`endif
      .wb_ack_i    (wb_ack_i),
      .busy        (busy),
      .done        (done),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_dat_o    (wb_dat_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({busy, done, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o});
   endfunction

   function automatic int model_n(input int raw);
      return (raw < 2) ? 2 : ((raw > 16) ? 16 : raw);
   endfunction

   function automatic int model_m(input int raw_n, input int raw_m, input int sr, input int sc);
      int n, cap, z;
      n = model_n(raw_n);
      cap = n * n - 1;
      z = 0;
`ifdef SAFE_ZONE_EN
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            if (r >= sr - 1 && r <= sr + 1 && c >= sc - 1 && c <= sc + 1) z++;
      if (n * n - z < cap) cap = n * n - z;
`else
      if (sr + sc < 0) z = 1;
      cap = cap - z;
`endif
      return (raw_m < cap) ? raw_m : cap;
   endfunction

   bit aborted;

   task automatic run_board(input string tag, input int raw_n, input int raw_m,
                            input int dmin, input int dmax, input int sr, input int sc,
                            input int exp_n, input int exp_m, input int abort_at, input bit poke);
      int nw, mines, dones, post, cyc_cnt, first_stb, wait_cnt, dly, cnt, nr, nc;
      bit pend_prev, acked_prev, finished, poked;
      logic [7:0] prev_adr, prev_dat;
      logic [7:0] adr_log [256];
      logic [7:0] dat_log [256];
      bit mine_map [16][16];
      nw = 0; mines = 0; dones = 0; post = 0; first_stb = -1; wait_cnt = 0; dly = 0;
      pend_prev = 0; acked_prev = 0; finished = 0; poked = 0; aborted = 0;
      prev_adr = '0; prev_dat = '0;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) mine_map[r][c] = 0;
      @(negedge clk);
      row_col_num = 5'(raw_n);
      mine_num    = 8'(raw_m);
`ifdef SAFE_ZONE_EN
      safe_row = 4'(sr);
      safe_col = 4'(sc);
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      row_col_num = 5'($urandom);
      mine_num    = 8'($urandom);
`ifdef SAFE_ZONE_EN
      safe_row = 4'($urandom);
      safe_col = 4'($urandom);
`endif
      chk({tag, "_busy_rise"}, int'(busy), 1);
      cyc_cnt = 1;
      while (!finished && cyc_cnt < BUDGET) begin
         start = 1'b0;
         wb_ack_i = 1'b0;
         if (abort_at >= 0 && nw == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk({tag, "_outs_in_reset"}, outs(), 0);
            finished = 1;
            aborted = 1;
         end else begin
            if (acked_prev) chk({tag, "_stb_gap"}, int'(wb_stb_o), 0);
            else if (pend_prev) begin
               chk({tag, "_hold_stb"}, int'(wb_stb_o), 1);
               chk({tag, "_hold_adr"}, int'(wb_adr_o), int'(prev_adr));
               chk({tag, "_hold_dat"}, int'(wb_dat_o), int'(prev_dat));
            end
            if (wb_stb_o) begin
               if (!pend_prev) begin
                  if (first_stb < 0) first_stb = cyc_cnt;
                  chk({tag, "_cyc_we"}, int'({wb_cyc_o, wb_we_o}), 3);
                  dly = int'($urandom_range(dmax, dmin));
                  wait_cnt = 0;
                  prev_adr = wb_adr_o;
                  prev_dat = wb_dat_o;
               end
               if (wait_cnt == dly) begin
                  wb_ack_i = 1'b1;
                  if (nw < 256) begin
                     adr_log[nw] = wb_adr_o;
                     dat_log[nw] = wb_dat_o;
                  end
                  nw++;
                  pend_prev = 0;
                  acked_prev = 1;
               end else begin
                  wait_cnt++;
                  pend_prev = 1;
                  acked_prev = 0;
               end
            end else begin
               pend_prev = 0;
               acked_prev = 0;
               if (dmax > 0 && $urandom_range(3, 0) == 0) wb_ack_i = 1'b1;
            end
            if (poke && !poked && nw == 3) begin
               start = 1'b1;
               row_col_num = 5'd5;
               mine_num = 8'd1;
               poked = 1;
            end
            if (done) begin
               dones++;
               chk({tag, "_busy_at_done"}, int'(busy), 0);
            end
            if (dones > 0) post++;
            if (post >= 4) finished = 1;
         end
         if (!finished) begin
            @(negedge clk);
            cyc_cnt++;
         end
      end
      wb_ack_i = 1'b0;
      start = 1'b0;
      if (!finished) chk({tag, "_timeout"}, 0, 1);
      if (finished && !aborted) begin
         chk({tag, "_nwrites"}, nw, exp_n * exp_n);
         for (int i = 0; i < nw && i < exp_n * exp_n; i++) begin
            chk($sformatf("%s_adr%0d", tag, i), int'(adr_log[i]), ((i / exp_n) << 4) | (i % exp_n));
            chk($sformatf("%s_zero%0d", tag, i), int'(dat_log[i][6:4]), 0);
            mine_map[i / exp_n][i % exp_n] = dat_log[i][7];
            if (dat_log[i][7]) mines++;
         end
         chk({tag, "_mines"}, mines, exp_m);
         for (int r = 0; r < exp_n; r++) begin
            for (int c = 0; c < exp_n; c++) begin
               cnt = 0;
               for (int dr = -1; dr <= 1; dr++)
                  for (int dc = -1; dc <= 1; dc++) begin
                     nr = r + dr;
                     nc = c + dc;
                     if ((dr != 0 || dc != 0) && nr >= 0 && nr < exp_n && nc >= 0 && nc < exp_n)
                        cnt += int'(mine_map[nr][nc]);
                  end
               if (r * exp_n + c < nw) begin
                  chk($sformatf("%s_cnt_r%0d_c%0d", tag, r, c), int'(dat_log[r * exp_n + c][3:0]), cnt);
                  if ((r == 0 || r == exp_n - 1) && (c == 0 || c == exp_n - 1))
                     chk($sformatf("%s_corner_le3_r%0d_c%0d", tag, r, c),
                         int'(dat_log[r * exp_n + c][3:0] <= 4'd3), 1);
               end
`ifdef SAFE_ZONE_EN
               if (r >= sr - 1 && r <= sr + 1 && c >= sc - 1 && c <= sc + 1)
                  chk($sformatf("%s_safe_r%0d_c%0d", tag, r, c), int'(mine_map[r][c]), 0);
`endif
            end
         end
         chk({tag, "_done_once"}, dones, 1);
         chk({tag, "_latency_ge_m2"}, int'(first_stb - 1 >= exp_m + 2), 1);
         chk({tag, "_idle_after"}, int'({busy, wb_stb_o}), 0);
      end
   endtask

   typedef struct {
      string tag;
      int    raw_n;
      int    raw_m;
      int    dmin;
      int    dmax;
      bit    poke;
      int    exp_n;
      int    exp_m;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int rn, rm, rdx, rsr, rsc;
      tbl[0] = '{"n9_m10_ack1", 9, 10, 1, 1, 1'b0, 9, 10};
      tbl[1] = '{"n9_m10_rnd",  9, 10, 0, 5, 1'b1, 9, 10};
      tbl[2] = '{"n2_m200",     2, 200, 0, 2, 1'b0, 2, 3};
      tbl[3] = '{"n20_m50",    20, 50, 0, 0, 1'b0, 16, 50};
      tbl[4] = '{"n0_m0",       0, 0, 1, 3, 1'b0, 2, 0};
      tbl[5] = '{"n16_m250",   16, 250, 0, 1, 1'b0, 16, 250};
      tbl[6] = '{"n5_m30",      5, 30, 0, 0, 1'b0, 5, 24};
      tbl[7] = '{"n1_m1",       1, 1, 2, 4, 1'b1, 2, 1};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_outs", outs(), 0);

      // start coinciding with reset is lost
      rst_n = 1'b0;
      start = 1'b1;
      row_col_num = 5'd9;
      mine_num = 8'd10;
      @(negedge clk);
      chk("rst_vs_start_busy", int'(busy), 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_vs_start_idle", outs(), 0);

      for (int i = 0; i < 8; i++)
         run_board(tbl[i].tag, tbl[i].raw_n, tbl[i].raw_m, tbl[i].dmin, tbl[i].dmax, 15, 15,
                   tbl[i].exp_n, tbl[i].exp_m, -1, tbl[i].poke);

      for (int k = 0; k < 4; k++) begin
         rn  = int'($urandom_range(31, 0));
         rm  = int'($urandom_range(255, 0));
         rdx = int'($urandom_range(5, 0));
         rsr = int'($urandom_range(15, 0));
         rsc = int'($urandom_range(15, 0));
         run_board($sformatf("rand%0d", k), rn, rm, 0, rdx, rsr, rsc,
                   model_n(rn), model_m(rn, rm, rsr, rsc), -1, 1'b1);
      end

      // reset mid-WRITE at field 40, then a full regeneration
      run_board("abort", 9, 10, 0, 2, 15, 15, 9, 10, 40, 1'b0);
      chk("abort_taken", int'(aborted), 1);
      @(negedge clk);
      chk("abort_outs_held", outs(), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_idle", outs(), 0);
      run_board("regen", 9, 10, 0, 3, 15, 15, 9, 10, -1, 1'b0);

`ifdef SAFE_ZONE_EN
      run_board("safe_n9_m80", 9, 80, 0, 1, 4, 4, 9, 72, -1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
